// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// One word per line; drives the backing memory pins directly and keeps
// saturating hit/miss counters.
module dcache_ctrl #(
  parameter int BLOCK_SIZE = 10,
  parameter int DATA_SIZE  = 32,
  parameter int INDEX_SIZE = 5,
  parameter int TAG_SIZE   = BLOCK_SIZE - INDEX_SIZE,
  parameter int CACHE_ROWS = 2**INDEX_SIZE,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [BLOCK_SIZE-1:0] cpu_addr,
  input  logic [DATA_SIZE-1:0]  cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_SIZE-1:0]  cpu_rdata,
  output logic [BLOCK_SIZE-1:0] mem_rdAddr,
  output logic                  mem_rdEn,
  input  logic [DATA_SIZE-1:0]  mem_data,
  output logic [BLOCK_SIZE-1:0] mem_wrAddr,
  output logic [DATA_SIZE-1:0]  mem_wrData,
  output logic                  mem_wrEn,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [CACHE_ROWS-1:0] valid_q;
  logic [CACHE_ROWS-1:0] dirty_q;
  logic [TAG_SIZE-1:0]   tag_mem  [CACHE_ROWS];
  logic [DATA_SIZE-1:0]  line_mem [CACHE_ROWS];

  logic [BLOCK_SIZE-1:0] addr_q;
  logic                  we_q;
  logic [DATA_SIZE-1:0]  wdata_q;
  logic                  refill_q;
  logic [DATA_SIZE-1:0]  rdata_q;

  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   addr_tag;
  logic                  hit;
  logic                  accept;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign idx      = addr_q[INDEX_SIZE-1:0];
  assign addr_tag = addr_q[BLOCK_SIZE-1:INDEX_SIZE];
  assign hit      = valid_q[idx] && (tag_mem[idx] == addr_tag);
  assign accept   = cpu_req && (state == IDLE);

  // Load data is forwarded from the line during the done cycle, then held.
  assign cpu_rdata = (cpu_done && !we_q) ? line_mem[idx] : rdata_q;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and state-decoded CPU/memory handshake outputs.
  always_comb begin
    state_nxt  = state;
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    mem_rdEn   = 1'b0;
    mem_rdAddr = '0;
    mem_wrEn   = 1'b0;
    mem_wrAddr = '0;
    mem_wrData = '0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_done  = 1'b1;
          state_nxt = IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_wrEn   = 1'b1;
        mem_wrAddr = {tag_mem[idx], idx};
        mem_wrData = line_mem[idx];
        state_nxt  = ALLOCATE;
      end
      ALLOCATE: begin
        mem_rdEn   = 1'b1;
        mem_rdAddr = addr_q;
        state_nxt  = COMPARE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line status bits, refill flag, held load data and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      refill_q   <= 1'b0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) refill_q <= 1'b0;
      if (state == COMPARE) begin
        if (!refill_q) begin
          if (hit) hit_count  <= sat_inc(hit_count);
          else     miss_count <= sat_inc(miss_count);
        end
        if (hit) begin
          if (we_q) dirty_q[idx] <= 1'b1;
          else      rdata_q      <= line_mem[idx];
        end
      end
      if (state == ALLOCATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
        refill_q     <= 1'b1;
      end
    end
  end

  // Request latch and line/tag storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cpu_addr;
      we_q    <= cpu_we;
      wdata_q <= cpu_wdata;
    end
    if ((state == COMPARE) && hit && we_q) line_mem[idx] <= wdata_q;
    if (state == ALLOCATE) begin
      line_mem[idx] <= mem_data;
      tag_mem[idx]  <= addr_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl with a request-level
// reference model (cache contents, coherent memory view, traffic, latency).
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic [9:0]  mem_rdAddr;
  logic        mem_rdEn;
  logic [31:0] mem_data;
  logic [9:0]  mem_wrAddr;
  logic [31:0] mem_wrData;
  logic        mem_wrEn;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;

  // Backing store: combinational read, write on the clock edge.
  logic [31:0] mem [1024];
  assign mem_data = mem[mem_rdAddr];
  always @(posedge clk) if (mem_wrEn) mem[mem_wrAddr] <= mem_wrData;

  // Reference model state.
  logic [31:0] gmem [1024];   // value the CPU must observe at each address
  logic [31:0] bmem [1024];   // expected backing-store contents
  logic        mv [32];
  logic        md [32];
  logic [4:0]  mt [32];
  logic [31:0] mline [32];
  int          m_hits;
  int          m_misses;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_rdAddr(mem_rdAddr), .mem_rdEn(mem_rdEn), .mem_data(mem_data),
    .mem_wrAddr(mem_wrAddr), .mem_wrData(mem_wrData), .mem_wrEn(mem_wrEn),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) gmem[i] = bmem[i];
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"},  32'(cpu_done), 0);
    check({tag, "_rdEn"},  32'(mem_rdEn), 0);
    check({tag, "_wrEn"},  32'(mem_wrEn), 0);
    check({tag, "_rdAddr"}, 32'(mem_rdAddr), 0);
    check({tag, "_wrAddr"}, 32'(mem_wrAddr), 0);
    check({tag, "_wrData"}, mem_wrData, 0);
    check({tag, "_hits"},  32'(hit_count), 0);
    check({tag, "_misses"}, 32'(miss_count), 0);
    check({tag, "_rdata"}, cpu_rdata, 0);
  endtask

  task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] wd);
    logic [4:0]  idx;
    logic [4:0]  tg;
    logic        hit;
    logic        wb;
    logic [9:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] exp_rd;
    logic [9:0]  rd_a;
    logic [9:0]  wr_a;
    logic [31:0] wr_d;
    int          exp_lat;
    int          lat;
    int          n_rd;
    int          n_wr;
    idx     = a[4:0];
    tg      = a[9:5];
    hit     = mv[idx] && (mt[idx] == tg);
    wb      = !hit && mv[idx] && md[idx];
    wb_a    = {mt[idx], idx};
    wb_d    = mline[idx];
    exp_rd  = gmem[a];
    exp_lat = hit ? 1 : (wb ? 4 : 3);
    rd_a    = '0;
    wr_a    = '0;
    wr_d    = '0;

    @(negedge clk);
    check("ready_before", 32'(cpu_ready), 1);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'(~we);
    cpu_addr  = 10'($urandom);
    cpu_wdata = $urandom;

    lat  = 0;
    n_rd = 0;
    n_wr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("rd_wr_excl", 32'(mem_rdEn & mem_wrEn), 0);
      if (mem_rdEn) begin
        n_rd++;
        rd_a = mem_rdAddr;
      end
      if (mem_wrEn) begin
        n_wr++;
        wr_a = mem_wrAddr;
        wr_d = mem_wrData;
      end
      if (cpu_done) begin
        lat = c;
        if (!we) check("rdata", cpu_rdata, exp_rd);
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("n_rdEn", n_rd, hit ? 0 : 1);
    check("n_wrEn", n_wr, wb ? 1 : 0);
    if (n_rd == 1) check("rdAddr", 32'(rd_a), 32'(a));
    if (n_wr == 1) begin
      check("wrAddr", 32'(wr_a), 32'(wb_a));
      check("wrData", wr_d, wb_d);
    end

    if (hit) m_hits++;
    else begin
      m_misses++;
      if (wb) bmem[wb_a] = wb_d;
      mline[idx] = bmem[a];
      mt[idx]    = tg;
      mv[idx]    = 1'b1;
      md[idx]    = 1'b0;
    end
    if (we) begin
      mline[idx] = wd;
      md[idx]    = 1'b1;
      gmem[a]    = wd;
    end

    @(negedge clk);
    check("done_pulse", 32'(cpu_done), 0);
    check("ready_after", 32'(cpu_ready), 1);
    if (!we) check("rdata_hold", cpu_rdata, exp_rd);
    if (wb) check("mem_after_wb", mem[wb_a], wb_d);
    check("hit_count", 32'(hit_count), m_hits);
    check("miss_count", 32'(miss_count), m_misses);
  endtask

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = $urandom;
      bmem[i] = mem[i];
    end
    mem[10'h045]  = 32'hDEADBEEF;
    bmem[10'h045] = 32'hDEADBEEF;
    mem[10'h0A5]  = 32'h0BADF00D;
    bmem[10'h0A5] = 32'h0BADF00D;
    model_reset();

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b1;

    // Directed sequence.
    do_req(1'b0, 10'h045, 32'h0);
    check("first_load_misses", 32'(miss_count), 1);
    do_req(1'b0, 10'h045, 32'h0);
    check("second_load_hits", 32'(hit_count), 1);
    do_req(1'b1, 10'h045, 32'h12345678);
    check("store_hit_no_mem_write", mem[10'h045], 32'hDEADBEEF);
    do_req(1'b0, 10'h045, 32'h0);
    do_req(1'b0, 10'h0A5, 32'h0);
    check("writeback_data", mem[10'h045], 32'h12345678);
    check("miss_after_conflict", 32'(miss_count), 2);
    do_req(1'b1, 10'h3E0, 32'h00000001);
    do_req(1'b0, 10'h3E0, 32'h0);

    // Randomized traffic on a few indices and tags to force conflicts.
    for (int n = 0; n < 300; n++) begin
      logic [9:0] a;
      a = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 7))};
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset during ALLOCATE of a clean miss on an untouched index.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 10'h1F0;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("alloc_rdEn", 32'(mem_rdEn), 1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("mid_alloc_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_req(1'b0, 10'h045, 32'h0);
    check("miss_after_reset", 32'(miss_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller placed between the CPU load/store port and the mem backing store. One cache line holds one DATA_SIZE word. The controller drives mem's rdAddr/rdEn/wrAddr/wrData/wrEn pins directly and samples mem's combinational data output. It also keeps hit and miss counters for performance checks.

Parameters:
BLOCK_SIZE, 10, word address width (matches mem)
DATA_SIZE, 32, data word width
INDEX_SIZE, 5, index bits = cpu_addr[INDEX_SIZE-1:0]
TAG_SIZE, BLOCK_SIZE-INDEX_SIZE, tag bits = cpu_addr[BLOCK_SIZE-1:INDEX_SIZE]
CACHE_ROWS, 2**INDEX_SIZE, number of lines
CNT_W, 16, width of the hit and miss counters

Ports:
clk  in  1  clock, all state updates on its rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cpu_req  in  1  request valid
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  BLOCK_SIZE  word address
cpu_wdata  in  DATA_SIZE  store data
cpu_ready  out  1  controller idle; the request is accepted on an edge where cpu_req=1 and cpu_ready=1
cpu_done  out  1  one-cycle pulse; the request has completed
cpu_rdata  out  DATA_SIZE  load data, valid while cpu_done=1, holds its value afterwards
mem_rdAddr  out  BLOCK_SIZE  to mem rdAddr
mem_rdEn  out  1  to mem rdEn
mem_data  in  DATA_SIZE  from mem data (combinational read)
mem_wrAddr  out  BLOCK_SIZE  to mem wrAddr
mem_wrData  out  DATA_SIZE  to mem wrData
mem_wrEn  out  1  to mem wrEn (mem writes on the clk edge)
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Per-line storage: valid, dirty, tag[TAG_SIZE], line[DATA_SIZE].
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valid and dirty bits clear; line and tag contents are don't-care.
  - cpu_rdata, hit_count and miss_count go to 0.
  - cpu_done and all mem_* outputs are 0 while in reset.
  - mem contents are untouched.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - cpu_ready=1.
  - On accept, latch addr/we/wdata, clear the refill flag, and go to COMPARE.
  - cpu_req while cpu_ready=0 is ignored; the CPU holds the request until it is accepted.
- COMPARE:
  - Hit is defined as valid[idx] && tag[idx]==addr tag.
  - Load hit: cpu_rdata<=line[idx], cpu_done=1 this cycle, go to IDLE.
  - Store hit: line[idx]<=wdata, dirty<=1, cpu_done=1, go to IDLE. No mem write.
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
  - Counters update only on the first COMPARE of a request (refill flag=0): a hit increments hit_count, a miss increments miss_count. Both saturate at all-ones.
  - The COMPARE after a refill is always a hit and is not counted.
- WRITEBACK (1 cycle):
  - mem_wrEn=1, mem_wrAddr={tag[idx],idx}, mem_wrData=line[idx].
  - Then go to ALLOCATE.
- ALLOCATE (1 cycle):
  - mem_rdEn=1, mem_rdAddr=latched addr.
  - At the edge: line<=mem_data, tag<=addr tag, valid<=1, dirty<=0, refill flag<=1.
  - Then go to COMPARE.
- mem_* outputs are decoded from state; mem_rdEn and mem_wrEn are 0 outside ALLOCATE and WRITEBACK, and are never both 1.
- Latency is counted from the accept edge to the cpu_done cycle:
  - Hit: 1 cycle.
  - Clean miss: 3 cycles.
  - Dirty miss: 4 cycles.
  - cpu_ready returns the cycle after cpu_done.
- A store miss is write-allocate: fetch the line, then the merged store in COMPARE sets dirty.
- Back-to-back requests: a new request is accepted at the earliest in the cycle after cpu_done; there is no overlap.
- Reset asserted mid-WRITEBACK/ALLOCATE aborts the transaction immediately. A partially issued writeback is lost; this is acceptable.

Test Plan:
- Reset; preload mem[0x045]=0xDEADBEEF; load 0x045 -> one mem_rdEn cycle with rdAddr=0x045, no wrEn; cpu_done 3 cycles after accept with cpu_rdata=0xDEADBEEF; miss_count=1.
- Load 0x045 again -> cpu_done 1 cycle after accept, rdata=0xDEADBEEF, no mem_* activity, hit_count=1.
- Store 0x12345678 to 0x045 -> hit; done after 1 cycle; mem_wrEn stays 0; mem[0x045] still 0xDEADBEEF; a following load returns 0x12345678.
- Load 0x0A5 (same index 5, tag 5), mem[0x0A5]=0x0BADF00D -> WRITEBACK with wrAddr=0x045 and wrData=0x12345678, then rdEn with rdAddr=0x0A5; done after 4 cycles with 0x0BADF00D; mem[0x045]=0x12345678; miss_count=2.
- Store 0x00000001 to clean-miss address 0x3E0 -> fetch of 0x3E0 with no writeback; done after 3 cycles; a following load of 0x3E0 hits and returns 0x00000001.
- Pull rst low during ALLOCATE -> cpu_done and mem_* go to 0 immediately and counters read 0; after release, load 0x045 misses (miss_count=1).
